// File: rtl/die_roll_ctrl.sv
// die_roll_ctrl: roll button front end for the six-sided die.
// Debounces the button, tumbles while held, settles, locks a face.
module die_roll_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TUMBLE_DIV      = 50000,
    parameter int SETTLE_STEPS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_btn,
    output logic [7:0] value,
    output logic       rolling,
    output logic       done,
    output logic [7:0] rolls
);

    localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIVW = (TUMBLE_DIV > 1) ? $clog2(TUMBLE_DIV) : 1;
    localparam int STW  = (SETTLE_STEPS > 1) ? $clog2(SETTLE_STEPS) : 1;

    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(TUMBLE_DIV - 1);
    localparam logic [STW-1:0]  STEP_LAST = STW'(SETTLE_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    logic            sync1;
    logic            btn_sync;
    logic            btn_stable;
    logic            btn_prev;
    logic [DBW-1:0]  db_cnt;
    logic [2:0]      face_ctr;
    logic [DIVW-1:0] div_q, div_d;
    logic [STW-1:0]  step_q, step_d;
    state_t          state_q, state_d;
    logic [2:0]      value_q, value_d;
    logic [7:0]      rolls_q, rolls_d;
    logic            done_q, done_d;
    logic            rolling_q;
    logic            rise, fall, tick;

    assign rise = btn_stable & ~btn_prev;
    assign fall = ~btn_stable & btn_prev;
    assign tick = (div_q == DIV_LAST);

    assign value   = {5'b00000, value_q};
    assign rolling = rolling_q;
    assign done    = done_q;
    assign rolls   = rolls_q;

    // Two-flop synchroniser, debounce counter and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            btn_sync   <= 1'b0;
            btn_stable <= 1'b0;
            btn_prev   <= 1'b0;
            db_cnt     <= '0;
        end else begin
            sync1    <= roll_btn;
            btn_sync <= sync1;
            btn_prev <= btn_stable;
            if (btn_sync == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_stable <= btn_sync;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Free-running face counter; its phase at a tick is the "random" face.
    always_ff @(posedge clk) begin
        if (rst) begin
            face_ctr <= 3'd1;
        end else if (face_ctr == 3'd6) begin
            face_ctr <= 3'd1;
        end else begin
            face_ctr <= face_ctr + 3'd1;
        end
    end

    // Next-state logic: tumble divider, settle steps, face latch, roll count.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        step_d  = step_q;
        value_d = value_q;
        rolls_d = rolls_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ROLL;
                    div_d   = '0;
                end
            end
            ROLL: begin
                if (tick) begin
                    value_d = face_ctr;
                end
                if (fall) begin
                    state_d = SETTLE;
                    step_d  = '0;
                end
            end
            SETTLE: begin
                // A re-press restarts the tumble and takes priority over the final tick.
                if (rise) begin
                    state_d = ROLL;
                    div_d   = '0;
                end else if (tick) begin
                    value_d = face_ctr;
                    if (step_q == STEP_LAST) begin
                        done_d  = 1'b1;
                        rolls_d = rolls_q + 8'd1;
                        state_d = IDLE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; rolling tracks the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            step_q    <= '0;
            value_q   <= 3'd0;
            rolls_q   <= 8'd0;
            done_q    <= 1'b0;
            rolling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            step_q    <= step_d;
            value_q   <= value_d;
            rolls_q   <= rolls_d;
            done_q    <= done_d;
            rolling_q <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_die_roll_ctrl.sv
// tb_die_roll_ctrl: directed scenarios for the die roll controller.
// Main instance uses short timings; a second instance exercises the roll count wrap.
module tb_die_roll_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       roll_btn;
    logic [7:0] value;
    logic       rolling;
    logic       done;
    logic [7:0] rolls;

    logic       w_rst;
    logic       w_btn;
    logic [7:0] w_value;
    logic       w_rolling;
    logic       w_done;
    logic [7:0] w_rolls;

    int         nchk = 0;
    int         nerr = 0;
    int         cyc  = 0;
    logic [7:0] vexp = 8'd0;

    always #5 clk = ~clk;

    // Non-reset edges since the last reset; face before edge e is (e-1)%6+1.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    die_roll_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TUMBLE_DIV(3),
        .SETTLE_STEPS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .roll_btn(roll_btn),
        .value(value),
        .rolling(rolling),
        .done(done),
        .rolls(rolls)
    );

    die_roll_ctrl #(
        .DEBOUNCE_CYCLES(1),
        .TUMBLE_DIV(1),
        .SETTLE_STEPS(1)
    ) dut_w (
        .clk(clk),
        .rst(w_rst),
        .roll_btn(w_btn),
        .value(w_value),
        .rolling(w_rolling),
        .done(w_done),
        .rolls(w_rolls)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        roll_btn = 1'b1;
        w_rst    = 1'b1;
        w_btn    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            nchk++;
            if (value !== 8'd0) begin
                nerr++;
                $display("FAIL reset_value got=%0d want=0", value);
            end
            nchk++;
            if (rolling !== 1'b0) begin
                nerr++;
                $display("FAIL reset_rolling got=%b want=0", rolling);
            end
            nchk++;
            if (done !== 1'b0) begin
                nerr++;
                $display("FAIL reset_done got=%b want=0", done);
            end
            nchk++;
            if (rolls !== 8'd0) begin
                nerr++;
                $display("FAIL reset_rolls got=%0d want=0", rolls);
            end
            nchk++;
            if (w_rolls !== 8'd0) begin
                nerr++;
                $display("FAIL reset_w_rolls got=%0d want=0", w_rolls);
            end
        end
        rst      = 1'b0;
        roll_btn = 1'b0;
        w_rst    = 1'b0;
        vexp     = 8'd0;
    endtask

    task automatic test_glitch();
        roll_btn = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            cycle();
            if (i == 3) roll_btn = 1'b0;
            nchk++;
            if (rolling !== 1'b0 || value !== 8'd0 || done !== 1'b0) begin
                nerr++;
                $display("FAIL glitch i=%0d got rolling=%b value=%0d done=%b want 0/0/0",
                         i, rolling, value, done);
            end
        end
    endtask

    task automatic test_full_roll();
        logic tk;
        roll_btn = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            cycle();
            if (i == 30) roll_btn = 1'b0;
            tk = (i >= 10) && (i <= 43) && ((i - 10) % 3 == 0);
            if (tk) vexp = 8'((cyc - 1) % 6 + 1);
            nchk++;
            if (value !== vexp) begin
                nerr++;
                $display("FAIL full_value i=%0d got=%0d want=%0d", i, value, vexp);
            end
            nchk++;
            if (rolling !== (i >= 7 && i < 43)) begin
                nerr++;
                $display("FAIL full_rolling i=%0d got=%b want=%b", i, rolling, (i >= 7 && i < 43));
            end
            nchk++;
            if (done !== (i == 43)) begin
                nerr++;
                $display("FAIL full_done i=%0d got=%b want=%b", i, done, (i == 43));
            end
            nchk++;
            if (rolls !== ((i >= 43) ? 8'd1 : 8'd0)) begin
                nerr++;
                $display("FAIL full_rolls i=%0d got=%0d want=%0d", i, rolls, (i >= 43) ? 1 : 0);
            end
        end
        nchk++;
        if (value < 8'd1 || value > 8'd6) begin
            nerr++;
            $display("FAIL full_final_range got=%0d want 1..6", value);
        end
    endtask

    task automatic test_repress_settle();
        logic tk;
        roll_btn = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            cycle();
            if (i == 12) roll_btn = 1'b0;
            if (i == 17) roll_btn = 1'b1;
            if (i == 30) roll_btn = 1'b0;
            tk = (i >= 10 && i <= 22 && (i - 10) % 3 == 0) ||
                 (i >= 27 && i <= 42 && (i - 27) % 3 == 0);
            if (tk) vexp = 8'((cyc - 1) % 6 + 1);
            nchk++;
            if (value !== vexp) begin
                nerr++;
                $display("FAIL repress_value i=%0d got=%0d want=%0d", i, value, vexp);
            end
            nchk++;
            if (rolling !== (i >= 7 && i < 42)) begin
                nerr++;
                $display("FAIL repress_rolling i=%0d got=%b want=%b", i, rolling, (i >= 7 && i < 42));
            end
            nchk++;
            if (done !== (i == 42)) begin
                nerr++;
                $display("FAIL repress_done i=%0d got=%b want=%b", i, done, (i == 42));
            end
            nchk++;
            if (rolls !== ((i >= 42) ? 8'd2 : 8'd1)) begin
                nerr++;
                $display("FAIL repress_rolls i=%0d got=%0d want=%0d", i, rolls, (i >= 42) ? 2 : 1);
            end
        end
    endtask

    task automatic test_reset_mid_roll();
        logic       tk;
        logic [7:0] rexp;
        roll_btn = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            cycle();
            if (i == 11) vexp = 8'd0;
            tk = (i == 10) || (i >= 21 && i <= 33 && (i - 21) % 3 == 0);
            if (tk) vexp = 8'((cyc - 1) % 6 + 1);
            rexp = (i < 11) ? 8'd2 : ((i >= 33) ? 8'd1 : 8'd0);
            nchk++;
            if (value !== vexp) begin
                nerr++;
                $display("FAIL midreset_value i=%0d got=%0d want=%0d", i, value, vexp);
            end
            nchk++;
            if (rolling !== ((i >= 7 && i <= 10) || (i >= 18 && i < 33))) begin
                nerr++;
                $display("FAIL midreset_rolling i=%0d got=%b", i, rolling);
            end
            nchk++;
            if (done !== (i == 33)) begin
                nerr++;
                $display("FAIL midreset_done i=%0d got=%b want=%b", i, done, (i == 33));
            end
            nchk++;
            if (rolls !== rexp) begin
                nerr++;
                $display("FAIL midreset_rolls i=%0d got=%0d want=%0d", i, rolls, rexp);
            end
            if (i == 10) rst = 1'b1;
            if (i == 11) rst = 1'b0;
            if (i == 22) roll_btn = 1'b0;
        end
    endtask

    task automatic test_wrap();
        int ndone = 0;
        for (int r = 1; r <= 256; r++) begin
            w_btn = 1'b1;
            for (int j = 1; j <= 12; j++) begin
                cycle();
                if (j == 2) w_btn = 1'b0;
                if (w_done === 1'b1) ndone++;
            end
            if (r == 1 || r == 255 || r == 256) begin
                nchk++;
                if (w_rolls !== 8'(r)) begin
                    nerr++;
                    $display("FAIL wrap_rolls roll=%0d got=%0d want=%0d", r, w_rolls, 8'(r));
                end
            end
        end
        nchk++;
        if (ndone != 256) begin
            nerr++;
            $display("FAIL wrap_done_count got=%0d want=256", ndone);
        end
        nchk++;
        if (w_value < 8'd1 || w_value > 8'd6 || w_rolling !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_final got value=%0d rolling=%b want 1..6/0", w_value, w_rolling);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        idle(4);
        test_full_roll();
        idle(5);
        test_repress_settle();
        idle(5);
        test_reset_mid_roll();
        idle(5);
        test_wrap();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
